// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
//
// Contents:
//   sub_state_t        FSM state encoding (IDLE, SHIFT, DONE)
//   SUB_WIDTH_DEFAULT  default operand/result width
//   sub_ovf()          signed overflow rule for A - B
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 4;

  // A - B overflows only when the operand signs differ and the result sign
  // disagrees with the minuend.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/fulladder.sv
// 1-bit full-adder cell.
//
// Ports:
//   a, b   in   addend bits
//   cin    in   carry in
//   sum    out  a ^ b ^ cin
//   cout   out  majority(a, b, cin)
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor_4b.sv
// Bit-serial subtractor: diff = A - B - bin, LSB first, one bit per clock.
//
// A single full-adder slice is fed the inverted subtrahend bit and the
// inverted borrow; with those inversions its sum is the difference bit and
// its inverted carry-out is the next borrow.
//
// Ports:
//   clk    in   clock, all state on posedge
//   reset  in   synchronous active-high reset
//   start  in   request, honoured in IDLE and DONE only
//   A      in   minuend, sampled on an accepted start
//   B      in   subtrahend, sampled on an accepted start
//   bin    in   borrow-in, sampled on an accepted start
//   busy   out  high while bits are processed
//   done   out  one-cycle pulse when diff/bout/ovf become valid
//   diff   out  difference, held until the next result
//   bout   out  borrow-out (1 = unsigned A < B + bin)
//   ovf    out  signed two's-complement overflow
module serial_subtractor_4b
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sub_state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic             br_q, br_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // Difference slice
  logic             d;
  logic             fa_cout;
  logic             br_next;
  logic [WIDTH-1:0] d_sr_shift;

  fulladder u_fa (
    .a    (a_sr_q[0]),
    .b    (~b_sr_q[0]),
    .cin  (~br_q),
    .sum  (d),
    .cout (fa_cout)
  );

  assign br_next = ~fa_cout;

  // Current difference bit enters at the MSB so the LSB lands at bit 0
  // after WIDTH shifts.
  always_comb begin
    d_sr_shift            = d_sr_q >> 1;
    d_sr_shift[WIDTH-1]   = d;
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    d_sr_d  = d_sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts start too, which gives back-to-back operation.
        if (start) begin
          state_d = SHIFT;
          a_sr_d  = A;
          b_sr_d  = B;
          br_d    = bin;
          d_sr_d  = '0;
          cnt_d   = '0;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = br_next;
        d_sr_d = d_sr_shift;
        if (cnt_q == CntLast) begin
          // Results are published only here, never bit by bit.
          state_d = DONE;
          diff_d  = d_sr_shift;
          bout_d  = br_next;
          ovf_d   = sub_ovf(a_msb_q, b_msb_q, d);
        end else begin
          // Counter stops at CntLast; it never wraps.
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_sr_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      d_sr_q  <= d_sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
